// File: rtl/axis_frame_checker.sv
// Frame checker: sums each AXI-Stream frame, counts its beats and compares the count against len.
// Latency: the result is valid one cycle after the last beat is accepted. Optional m_max output under `FRAME_MAX_EN.
// Backpressure: s_ready is low while a result waits for m_ready, giving one bubble per frame.
module axis_frame_checker #(
    parameter int Data_width = 16,
    parameter int Sum_width  = 32,
    parameter int Cnt_width  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [Data_width-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic [Data_width-1:0] len,
    output logic [Sum_width-1:0]  m_sum,
    output logic [Cnt_width-1:0]  m_count,
    output logic                  m_err,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [Cnt_width-1:0]  frame_cnt,
    output logic                  busy
`ifdef FRAME_MAX_EN
    ,
    output logic [Data_width-1:0] m_max
`endif
);

    localparam int Cmp_width = (Data_width > Cnt_width) ? Data_width : Cnt_width;

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                state;
    logic [Sum_width-1:0]  sum;
    logic [Cnt_width-1:0]  count;
    logic [Data_width-1:0] len_q;

    logic                  beat;
    logic [Cnt_width-1:0]  count_inc;
    logic [Data_width-1:0] len_eff;
    logic [Sum_width-1:0]  sum_nxt;

    assign beat      = s_valid & s_ready;
    assign count_inc = (&count) ? count : count + 1'b1;
    // A single-beat frame has not registered len yet, so compare against the live port.
    assign len_eff   = (count == '0) ? len : len_q;
    assign sum_nxt   = sum + Sum_width'(s_data);
    assign busy      = (state == ACCUM) && (count != '0);

`ifdef FRAME_MAX_EN
    logic [Data_width-1:0] max_q;
    logic [Data_width-1:0] max_nxt;
    assign max_nxt = (s_data > max_q) ? s_data : max_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ACCUM;
            sum       <= '0;
            count     <= '0;
            len_q     <= '0;
            m_sum     <= '0;
            m_count   <= '0;
            m_err     <= 1'b0;
            m_valid   <= 1'b0;
            frame_cnt <= '0;
            s_ready   <= 1'b0;
`ifdef FRAME_MAX_EN
            max_q     <= '0;
            m_max     <= '0;
`endif
        end else begin
            case (state)
                ACCUM: begin
                    s_ready <= 1'b1;
                    if (beat) begin
                        if (count == '0) begin
                            len_q <= len;
                        end
                        if (s_last) begin
                            m_sum   <= sum_nxt;
                            m_count <= count_inc;
                            m_err   <= Cmp_width'(count_inc) != Cmp_width'(len_eff);
                            m_valid <= 1'b1;
                            s_ready <= 1'b0;
                            sum     <= '0;
                            count   <= '0;
                            state   <= HOLD;
`ifdef FRAME_MAX_EN
                            m_max   <= max_nxt;
                            max_q   <= '0;
`endif
                        end else begin
                            sum   <= sum_nxt;
                            count <= count_inc;
`ifdef FRAME_MAX_EN
                            max_q <= max_nxt;
`endif
                        end
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid   <= 1'b0;
                        frame_cnt <= frame_cnt + 1'b1;
                        s_ready   <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_checker.sv
// Bench for axis_frame_checker: directed frame table, hand-written corner sequences and a random phase
// checked every cycle against a frame-level reference model.
module tb_axis_frame_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [15:0] len = '0;
    logic [31:0] m_sum;
    logic [15:0] m_count;
    logic        m_err;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] frame_cnt;
    logic        busy;

    logic        s_ready16;
    logic [15:0] m_sum16;
    logic [15:0] m_count16;
    logic        m_err16;
    logic        m_valid16;
    logic [15:0] frame_cnt16;
    logic        busy16;
`ifdef FRAME_MAX_EN
    logic [15:0] m_max;
    logic [15:0] m_max16;
`endif

    axis_frame_checker #(.Data_width(16), .Sum_width(32), .Cnt_width(16)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .len(len), .m_sum(m_sum), .m_count(m_count), .m_err(m_err),
        .m_valid(m_valid), .m_ready(m_ready), .frame_cnt(frame_cnt), .busy(busy)
`ifdef FRAME_MAX_EN
        , .m_max(m_max)
`endif
    );

    axis_frame_checker #(.Data_width(16), .Sum_width(16), .Cnt_width(16)) dut16 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready16), .len(len), .m_sum(m_sum16), .m_count(m_count16), .m_err(m_err16),
        .m_valid(m_valid16), .m_ready(m_ready), .frame_cnt(frame_cnt16), .busy(busy16)
`ifdef FRAME_MAX_EN
        , .m_max(m_max16)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: beats of the open frame kept in a queue; the result is computed from it at s_last.
    logic [15:0] q[$];
    logic [15:0] len_s = '0;
    bit          pend = 0;
    bit          rdy = 0;
    logic [15:0] fc = '0;
    logic [31:0] r_sum = '0;
    logic [15:0] r_sum16 = '0;
    logic [15:0] r_cnt = '0;
    logic        r_err = 1'b0;
    logic [15:0] r_max = '0;

    task automatic model_edge();
        longint s;
        logic [15:0] mx;
        if (!rst) begin
            q.delete();
            pend = 0; rdy = 0; fc = '0; len_s = '0;
            r_sum = '0; r_sum16 = '0; r_cnt = '0; r_err = 1'b0; r_max = '0;
        end else if (pend) begin
            if (m_ready) begin
                pend = 0; fc = fc + 16'd1; rdy = 1;
            end
        end else begin
            if (s_valid && rdy) begin
                if (q.size() == 0) len_s = len;
                q.push_back(s_data);
                if (s_last) begin
                    s = 0; mx = '0;
                    foreach (q[i]) begin
                        s += longint'(q[i]);
                        if (q[i] > mx) mx = q[i];
                    end
                    r_sum   = s[31:0];
                    r_sum16 = s[15:0];
                    r_cnt   = (q.size() > 65535) ? 16'hFFFF : 16'(q.size());
                    r_err   = (r_cnt != len_s);
                    r_max   = mx;
                    q.delete();
                    pend = 1;
                end
            end
            rdy = !pend;
        end
    endtask

    task automatic model_cmp();
        chk("s_ready", 32'(s_ready), 32'(rdy));
        chk("m_valid", 32'(m_valid), 32'(pend));
        chk("busy", 32'(busy), 32'(!pend && q.size() != 0));
        chk("frame_cnt", 32'(frame_cnt), 32'(fc));
        chk("m_sum", m_sum, r_sum);
        chk("m_count", 32'(m_count), 32'(r_cnt));
        chk("m_err", 32'(m_err), 32'(r_err));
        chk("w16 m_sum", 32'(m_sum16), 32'(r_sum16));
        chk("w16 m_count", 32'(m_count16), 32'(r_cnt));
        chk("w16 m_err", 32'(m_err16), 32'(r_err));
        chk("w16 handshake", 32'({s_ready16, m_valid16, busy16}), 32'({rdy, pend, !pend && q.size() != 0}));
        chk("w16 frame_cnt", 32'(frame_cnt16), 32'(fc));
`ifdef FRAME_MAX_EN
        chk("m_max", 32'(m_max), 32'(r_max));
        chk("w16 m_max", 32'(m_max16), 32'(r_max));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        model_cmp();
    endtask

    task automatic send_frame(input int lenv, input int n, input int base, input int step, input int gap);
        bit acc;
        int guard;
        len = 16'(lenv);
        for (int k = 0; k < n; k++) begin
            s_valid = 1'b1;
            s_data  = 16'(base + k * step);
            s_last  = (k == n - 1);
            guard = 0;
            do begin
                acc = rdy;
                tick();
                guard++;
            end while (!acc && guard < 50);
            if (!acc) chk("beat accept timeout", 32'(guard), 32'd0);
            // len must only matter at the first beat
            if (k == 0) len = 16'($urandom);
            s_valid = 1'b0;
            s_data  = 16'($urandom);
            s_last  = 1'($urandom);
            if (k != n - 1) repeat (gap) tick();
        end
        s_last = 1'b0;
    endtask

    task automatic handshake(input logic [15:0] exp_fc);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("frame_cnt after handshake", 32'(frame_cnt), 32'(exp_fc));
        chk("m_valid after handshake", 32'(m_valid), 32'd0);
    endtask

    typedef struct {
        int          lenv;
        int          n;
        int          base;
        int          step;
        int          gap;
        logic [31:0] e_sum;
        logic [15:0] e_sum16;
        logic [15:0] e_cnt;
        logic        e_err;
        logic [15:0] e_max;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{10, 10, 2, 2, 0, 32'd110, 16'd110, 16'd10, 1'b0, 16'd20};
        vecs[1] = '{10, 8, 1, 0, 1, 32'd8, 16'd8, 16'd8, 1'b1, 16'd1};
        vecs[2] = '{10, 12, 1, 0, 0, 32'd12, 16'd12, 16'd12, 1'b1, 16'd1};
        vecs[3] = '{1, 1, 7, 0, 0, 32'd7, 16'd7, 16'd1, 1'b0, 16'd7};
        vecs[4] = '{0, 3, 5, 0, 2, 32'd15, 16'd15, 16'd3, 1'b1, 16'd5};
        vecs[5] = '{2, 2, 65535, 0, 0, 32'h0001_FFFE, 16'hFFFE, 16'd2, 1'b0, 16'hFFFF};

        // Reset held two cycles, then released.
        rst = 1'b0;
        tick();
        tick();
        chk("reset s_ready", 32'(s_ready), 32'd0);
        chk("reset outputs", 32'({m_valid, m_err, busy}), 32'd0);
        chk("reset m_sum", m_sum, 32'd0);
        chk("reset counts", 32'({m_count, frame_cnt}), 32'd0);
        rst = 1'b1;
        tick();
        chk("s_ready after release", 32'(s_ready), 32'd1);

        // Directed frame table.
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].lenv, vecs[i].n, vecs[i].base, vecs[i].step, vecs[i].gap);
            chk("tbl m_valid", 32'(m_valid), 32'd1);
            chk("tbl m_sum", m_sum, vecs[i].e_sum);
            chk("tbl m_sum w16", 32'(m_sum16), 32'(vecs[i].e_sum16));
            chk("tbl m_count", 32'(m_count), 32'(vecs[i].e_cnt));
            chk("tbl m_err", 32'(m_err), 32'(vecs[i].e_err));
`ifdef FRAME_MAX_EN
            chk("tbl m_max", 32'(m_max), 32'(vecs[i].e_max));
`endif
            handshake(16'(i + 1));
        end

        // Back-pressure: next frame's first beat waits on the bus while the result is held.
        send_frame(3, 3, 1, 1, 0);
        len     = 16'd2;
        s_valid = 1'b1;
        s_data  = 16'd100;
        s_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp m_valid held", 32'(m_valid), 32'd1);
            chk("bp s_ready low", 32'(s_ready), 32'd0);
            chk("bp m_sum held", m_sum, 32'd6);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("bp s_ready after handshake", 32'(s_ready), 32'd1);
        tick();
        chk("bp held beat taken", 32'(busy), 32'd1);
        s_data = 16'd200;
        s_last = 1'b1;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("bp next m_sum", m_sum, 32'd300);
        chk("bp next m_count", 32'(m_count), 32'd2);
        chk("bp next m_err", 32'(m_err), 32'd0);
        handshake(16'd8);

        // Reset mid-frame discards the partial frame.
        len = 16'd10;
        s_valid = 1'b1;
        s_last  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_data = 16'd1000 + 16'(k);
            tick();
        end
        s_valid = 1'b0;
        chk("partial busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("async reset busy", 32'(busy), 32'd0);
        chk("async reset m_valid", 32'(m_valid), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        send_frame(10, 10, 5, 3, 0);
        chk("post-reset m_count", 32'(m_count), 32'd10);
        chk("post-reset m_sum", m_sum, 32'd185);
        chk("post-reset m_err", 32'(m_err), 32'd0);
`ifdef FRAME_MAX_EN
        chk("post-reset m_max", 32'(m_max), 32'd32);
`endif
        handshake(16'd1);

        // Random phase.
        for (int c = 0; c < 3000; c++) begin
            s_valid = ($urandom_range(3) != 0);
            s_data  = (c < 1500) ? 16'($urandom) : 16'($urandom_range(15));
            s_last  = ($urandom_range(4) == 0);
            len     = 16'($urandom_range(5));
            m_ready = ($urandom_range(2) != 0);
            rst     = ($urandom_range(199) != 0);
            tick();
        end
        rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_frame_checker.md
Name: axis_frame_checker

Overview:
- Downstream consumer of the AXI-Stream frame buffer's master port; accepts one frame at a time, accumulates a running sum and beat count, and checks the frame length against the configured `len`.
- Emits one result word per frame on a small AXI-Stream-like result port for the status/debug path.
- Holds the upstream stage in back-pressure while an unread result is pending.

Parameters:
- Data_width, 16, width of input beat data and of `len`.
- Sum_width, 32, width of the frame sum accumulator; must be >= Data_width.
- Cnt_width, 16, width of the beat counter and of `frame_cnt`.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- s_data  input  Data_width  stream beat data, unsigned.
- s_valid  input  1  beat valid.
- s_last  input  1  marks the final beat of a frame.
- s_ready  output  1  block can accept a beat.
- len  input  Data_width  expected beats per frame; sampled at first beat of each frame.
- m_sum  output  Sum_width  sum of all data beats in the completed frame.
- m_count  output  Cnt_width  beats received in the completed frame.
- m_err  output  1  1 = m_count differs from the sampled len.
- m_valid  output  1  result valid.
- m_ready  input  1  result consumer ready.
- frame_cnt  output  Cnt_width  total results accepted downstream since reset; wraps.
- busy  output  1  1 = a frame is partially received (ACCUM with count > 0).

Behaviour:
- Reset (rst=0, async): state=ACCUM, sum=0, count=0, len_q=0, m_sum=0, m_count=0, m_err=0, m_valid=0, frame_cnt=0, busy=0. s_ready comes up 1 in the first cycle after reset deasserts.
- States: ACCUM, HOLD.
- ACCUM:
  - s_ready=1, m_valid=0.
  - Beat accepted when s_valid & s_ready.
  - First beat of a frame (count==0): len_q <= len.
  - Non-last beat: sum <= sum + s_data (zero-extended, wraps modulo 2^Sum_width); count <= count+1, saturating at all-ones.
  - Last beat (s_last=1):
    - m_sum <= sum + s_data; m_count <= count+1 (saturating).
    - m_err <= ((count+1) != len_q_eff), where len_q_eff = len when count==0, else len_q.
    - sum <= 0, count <= 0, state -> HOLD.
- HOLD:
  - s_ready=0, m_valid=1; outputs stable until handshake.
  - On m_ready: m_valid <= 0, frame_cnt <= frame_cnt+1 (wraps), state -> ACCUM.
- Latency: m_valid asserts the cycle after the last beat is accepted.
- Throughput: the cycle after the result handshake is the earliest a new beat is accepted, i.e. one bubble per frame. The upstream buffer absorbs this.
- Single-beat frame (s_last on first beat): m_count=1, m_sum=s_data, m_err = (len != 1).
- len==0: every frame reports m_err=1.
- Frame longer than len: keep accumulating; m_err=1 at s_last.
- s_valid=0 mid-frame: no state change, busy stays 1.
- busy = (state==ACCUM) & (count != 0).
- s_data / s_last are ignored when s_valid=0.
- Reset mid-frame or in HOLD: partial frame and pending result are discarded; no result is emitted.
- m_ready is ignored in ACCUM.

Optional Feature:
- Macro FRAME_MAX_EN.
- Defined: adds output port `m_max` (Data_width), the maximum s_data beat in the completed frame.
  - Running max resets to 0 at reset and at frame end.
  - m_max updates together with m_sum; reset value 0.
- Undefined: the port and the max register do not exist; all other behaviour is identical.

Test Plan:
- Reset check: rst=0 held 2 cycles, then released -> all outputs 0, s_ready=1 one cycle after release.
- Nominal frame: len=10, beats 2,4,...,20, s_last on 10th beat, m_ready=1 -> m_valid 1 cycle later; m_sum=110, m_count=10, m_err=0; frame_cnt=1.
- Length mismatch: len=10, 8 beats of value 1 with s_last on 8th -> m_count=8, m_sum=8, m_err=1; then 12 beats -> m_count=12, m_err=1.
- Back-pressure: m_ready=0 for 5 cycles after frame end -> m_valid and outputs held, s_ready=0 throughout, no beats lost. m_ready=1 -> next frame accepted from the following cycle.
- Wrap/saturation: Sum_width=16, 2 beats of 16'hFFFF with s_last on 2nd -> m_sum=16'hFFFE. Single-beat frame with len=1 -> m_count=1, m_err=0.
- Reset mid-frame: 4 beats accepted, then rst pulsed -> no result emitted, busy=0. The next 10-beat frame reports m_count=10 (with FRAME_MAX_EN: m_max = largest beat).
